// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction-memory geometry, loader framing and
// the loader's state / error encodings.
package y86_pkg;

    localparam int         IMEM_DEPTH  = 1024;
    localparam int         IMEM_ADDR_W = 10;
    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_CSUM  = 2'd2
    } loader_err_t;

    // True when [start, start+len) does not fit below depth. The sum is
    // carried 17 bits wide so a large len can never wrap back into range.
    function automatic logic frame_overflows(input logic [16:0] start,
                                             input logic [15:0] len,
                                             input int          depth);
        logic [16:0] end_addr;
        end_addr = start + {1'b0, len};
        return end_addr > 17'(depth);
    endfunction

endpackage

// File: rtl/y86_imem_loader_if.sv
// Byte-link input and instruction-memory write port of the loader.
// master = host link / memory side, slave = the loader.
interface y86_imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;

    modport master (
        output in_valid, in_data, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/y86_imem_wr_stage.sv
// Single-entry write output register. A loaded byte is presented on the
// memory port the next cycle and held with stable addr/data until taken.
module y86_imem_wr_stage #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              retire
);

    assign retire = valid && ready;

    // Load wins over retire so accept+retire in one cycle gives back-to-back
    // writes; the caller only loads when the slot is empty or retiring.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= ld_addr;
            data  <= ld_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/y86_imem_loader.sv
// Y86 instruction-memory loader: parses SYNC/addr/len/payload/checksum
// frames from a byte link, writes the payload into the instruction store
// and releases the CPU once a frame has loaded with a good checksum.
module y86_imem_loader
    import y86_pkg::*;
#(
    parameter int         ADDR_W = IMEM_ADDR_W,
    parameter int         DEPTH  = IMEM_DEPTH,
    parameter logic [7:0] SYNC   = LOADER_SYNC
) (
    input  logic                clk,
    input  logic                reset,
    y86_imem_loader_if.slave    bus,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err,
    output logic [1:0]          err_code,
    output logic [ADDR_W:0]     bytes_written
);

    localparam int HI_W = ADDR_W - 8;

    loader_state_t     state, state_nx;
    logic [1:0]        hdr_cnt;
    logic [7:0]        addr_lo;
    logic [HI_W-1:0]   addr_hi;
    logic [7:0]        len_lo;
    logic [15:0]       remaining;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        csum;
    loader_err_t       err_q;

    logic              in_ready;
    logic              accept;
    logic              wr_valid;
    logic              wr_load;
    logic              wr_retire;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    logic [ADDR_W-1:0] hdr_addr;
    logic [15:0]       hdr_len;
    logic              hdr_bad;

    // Header fields as they stand when the last header byte is on the link;
    // address bits above ADDR_W are never stored.
    assign hdr_addr = {addr_hi, addr_lo};
    assign hdr_len  = {bus.in_data, len_lo};
    assign hdr_bad  = frame_overflows(17'(hdr_addr), hdr_len, DEPTH);

    assign accept  = bus.in_valid && in_ready;
    assign wr_load = accept && (state == DATA);

    assign bus.in_ready = in_ready;
    assign bus.wr_valid = wr_valid;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign err_code     = err_q;

    // Link backpressure: payload and checksum wait for the write slot.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE, HDR:  in_ready = 1'b1;
            DATA, CSUM: in_ready = !wr_valid || bus.wr_ready;
            default:    in_ready = 1'b0;
        endcase
        if (reset) in_ready = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; SYNC outside IDLE is ordinary data.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && bus.in_data == SYNC) state_nx = HDR;
            HDR: begin
                if (accept && hdr_cnt == 2'd3) begin
                    if (hdr_bad)            state_nx = ERR;
                    else if (hdr_len == '0) state_nx = CSUM;
                    else                    state_nx = DATA;
                end
            end
            DATA:    if (accept && remaining == 16'd1) state_nx = CSUM;
            CSUM:    if (accept) state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Header capture, payload counters, checksum and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt       <= '0;
            addr_lo       <= '0;
            addr_hi       <= '0;
            len_lo        <= '0;
            remaining     <= '0;
            cur_addr      <= '0;
            csum          <= '0;
            err_q         <= ERR_NONE;
            bytes_written <= '0;
            cpu_hold      <= 1'b1;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if (wr_retire) bytes_written <= bytes_written + 1'b1;
            case (state)
                IDLE: begin
                    if (accept && bus.in_data == SYNC) begin
                        hdr_cnt       <= '0;
                        csum          <= '0;
                        err_q         <= ERR_NONE;
                        bytes_written <= '0;
                        cpu_hold      <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                        case (hdr_cnt)
                            2'd0: addr_lo <= bus.in_data;
                            2'd1: addr_hi <= bus.in_data[HI_W-1:0];
                            2'd2: len_lo  <= bus.in_data;
                            default: begin
                                remaining <= hdr_len;
                                cur_addr  <= hdr_addr;
                                if (hdr_bad) begin
                                    err_q    <= ERR_RANGE;
                                    load_err <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum      <= csum ^ bus.in_data;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 16'd1;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (bus.in_data == csum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                            err_q    <= ERR_CSUM;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    y86_imem_wr_stage #(.ADDR_W(ADDR_W)) u_wr_stage (
        .clk     (clk),
        .reset   (reset),
        .load    (wr_load),
        .ld_addr (cur_addr),
        .ld_data (bus.in_data),
        .ready   (bus.wr_ready),
        .valid   (wr_valid),
        .addr    (wr_addr),
        .data    (wr_data),
        .retire  (wr_retire)
    );

endmodule

// File: tb/tb_y86_imem_loader.sv
// Directed bench for the Y86 instruction-memory loader: per-cycle vector
// table of link/memory inputs and expected outputs, plus reset sequences.
module tb_y86_imem_loader;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_hold, load_done, load_err;
    logic [1:0]  err_code;
    logic [10:0] bytes_written;

    always #5 clk = ~clk;

    y86_imem_loader_if #(.ADDR_W(10)) bus ();

    y86_imem_loader dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_err      (load_err),
        .err_code      (err_code),
        .bytes_written (bytes_written)
    );

    typedef struct {
        logic        iv;
        logic [7:0]  id;
        logic        rdy;
        logic        e_ir;
        logic        e_wv;
        logic [9:0]  e_wa;
        logic [7:0]  e_wd;
        logic        e_hold;
        logic        e_done;
        logic        e_err;
        logic [1:0]  e_ec;
        logic [10:0] e_bw;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(logic iv, logic [7:0] id, logic rdy,
                                logic ir, logic wv, logic [9:0] wa, logic [7:0] wd,
                                logic hold, logic done, logic err,
                                logic [1:0] ec, logic [10:0] bw);
        vec_t v;
        v.iv = iv; v.id = id; v.rdy = rdy;
        v.e_ir = ir; v.e_wv = wv; v.e_wa = wa; v.e_wd = wd;
        v.e_hold = hold; v.e_done = done; v.e_err = err;
        v.e_ec = ec; v.e_bw = bw;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Packed {ir,wv,wa,wd,hold,done,err,ec,bw}; addr/data only matter
    // while a write is expected to be presented.
    task automatic run_vecs(string tag);
        logic [63:0] act, exp;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            bus.in_valid = vecs[i].iv;
            bus.in_data  = vecs[i].id;
            bus.wr_ready = vecs[i].rdy;
            @(negedge clk);
            act = {28'd0, bus.in_ready, bus.wr_valid,
                   vecs[i].e_wv ? bus.wr_addr : 10'd0,
                   vecs[i].e_wv ? bus.wr_data : 8'd0,
                   cpu_hold, load_done, load_err, err_code, bytes_written};
            exp = {28'd0, vecs[i].e_ir, vecs[i].e_wv,
                   vecs[i].e_wv ? vecs[i].e_wa : 10'd0,
                   vecs[i].e_wv ? vecs[i].e_wd : 8'd0,
                   vecs[i].e_hold, vecs[i].e_done, vecs[i].e_err,
                   vecs[i].e_ec, vecs[i].e_bw};
            chk($sformatf("%s[%0d]", tag, i), act, exp);
        end
        vecs.delete();
    endtask

    // Frame A5 00 00 03 00 30 F4 00 C4 with the memory always ready.
    function automatic void add_frame_a(logic ph, logic [10:0] pbw, logic [1:0] pec);
        add(1, 8'hA5, 1,  1, 0, 10'h0, 8'h00,  ph, 0, 0, pec, pbw);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h03, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h30, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'hF4, 1,  1, 1, 10'h0, 8'h30,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 1, 10'h1, 8'hF4,  1, 0, 0, 0, 1);
        add(1, 8'hC4, 1,  1, 1, 10'h2, 8'h00,  1, 0, 0, 0, 2);
        add(0, 8'h00, 1,  1, 0, 10'h0, 8'h00,  0, 1, 0, 0, 3);
        add(0, 8'h00, 1,  1, 0, 10'h0, 8'h00,  0, 0, 0, 0, 3);
    endfunction

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.wr_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("ready_in_reset", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state",
            {48'd0, bus.in_ready, bus.wr_valid, cpu_hold, load_done, load_err, err_code, bytes_written},
            {48'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 11'd0});
        chk("reset_wr_bus", {46'd0, bus.wr_addr, bus.wr_data}, 64'd0);

        // A: basic load
        add_frame_a(1, 0, 0);

        // B: same frame, second write stalled three cycles
        add(1, 8'hA5, 1,  1, 0, 10'h0, 8'h00,  0, 0, 0, 0, 3);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h03, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h30, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'hF4, 1,  1, 1, 10'h0, 8'h30,  1, 0, 0, 0, 0);
        add(1, 8'h00, 0,  0, 1, 10'h1, 8'hF4,  1, 0, 0, 0, 1);
        add(1, 8'h00, 0,  0, 1, 10'h1, 8'hF4,  1, 0, 0, 0, 1);
        add(1, 8'h00, 0,  0, 1, 10'h1, 8'hF4,  1, 0, 0, 0, 1);
        add(1, 8'h00, 1,  1, 1, 10'h1, 8'hF4,  1, 0, 0, 0, 1);
        add(1, 8'hC4, 1,  1, 1, 10'h2, 8'h00,  1, 0, 0, 0, 2);
        add(0, 8'h00, 1,  1, 0, 10'h0, 8'h00,  0, 1, 0, 0, 3);

        // C: addr 0x3FE len 3 overflows; rest of frame is dropped garbage
        add(1, 8'hA5, 1,  1, 0, 10'h0, 8'h00,  0, 0, 0, 0, 3);
        add(1, 8'hFE, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h03, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h03, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(0, 8'h00, 1,  0, 0, 10'h0, 8'h00,  1, 0, 1, 1, 0);
        add(1, 8'h30, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 1, 0);
        add(1, 8'hF4, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 1, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 1, 0);
        add(1, 8'hC4, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 1, 0);
        add_frame_a(1, 0, 1);

        // D: len 2 at 0x010, payload 10 20, bad checksum 00
        add(1, 8'hA5, 1,  1, 0, 10'h000, 8'h00,  0, 0, 0, 0, 3);
        add(1, 8'h10, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h02, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h10, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h20, 1,  1, 1, 10'h010, 8'h10,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 1, 10'h011, 8'h20,  1, 0, 0, 0, 1);
        add(0, 8'h00, 1,  1, 0, 10'h000, 8'h00,  1, 0, 1, 2, 2);
        add(0, 8'h00, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 2, 2);

        // E: garbage, then one byte at the top address 0x3FF
        add(1, 8'h00, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 2, 2);
        add(1, 8'hFF, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 2, 2);
        add(1, 8'h12, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 2, 2);
        add(1, 8'hA5, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 2, 2);
        add(1, 8'hFF, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h03, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h01, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h000, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 1, 10'h3FF, 8'h00,  1, 0, 0, 0, 0);
        add(0, 8'h00, 1,  1, 0, 10'h000, 8'h00,  0, 1, 0, 0, 1);

        // F: zero-length frame goes straight to checksum
        add(1, 8'hA5, 1,  1, 0, 10'h0, 8'h00,  0, 0, 0, 0, 1);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 1,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(0, 8'h00, 1,  1, 0, 10'h0, 8'h00,  0, 1, 0, 0, 0);
        run_vecs("vec");

        // Reset mid-DATA with a write pending against a stalled memory
        add(1, 8'hA5, 0,  1, 0, 10'h0, 8'h00,  0, 0, 0, 0, 0);
        add(1, 8'h00, 0,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 0,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h03, 0,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h00, 0,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'h30, 0,  1, 0, 10'h0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 8'hF4, 0,  0, 1, 10'h0, 8'h30,  1, 0, 0, 0, 0);
        run_vecs("pre_rst");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready_low", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_data",
            {48'd0, bus.in_ready, bus.wr_valid, cpu_hold, load_done, load_err, err_code, bytes_written},
            {48'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 11'd0});

        // A full frame loads normally after the abort
        add_frame_a(1, 0, 0);
        run_vecs("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/y86_imem_loader.md
Name: y86_imem_loader

Overview:
- Writer side of the Y86 instruction memory: receives a framed byte stream and writes the program bytes into the 1024-byte instruction store that fetch reads.
- Holds the processor (`cpu_hold`) until one frame has loaded and passed its checksum.
- Replaces the file preload for bring-up and reload; sits between the host byte link and the instruction-memory write port.

Parameters:
- ADDR_W, 10, instruction-memory address width.
- DEPTH, 1024, instruction-memory size in bytes; a frame must fit entirely within it.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader accepts `in_data` this cycle.
- wr_valid  out  1  memory write request.
- wr_addr  out  ADDR_W  write byte address.
- wr_data  out  8  write byte.
- wr_ready  in  1  memory accepts the write this cycle.
- cpu_hold  out  1  processor must not advance PC while high.
- load_done  out  1  one-cycle pulse: frame loaded, checksum good.
- load_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  2  0 none, 1 range, 2 checksum; holds until the next frame's SYNC.
- bytes_written  out  ADDR_W+1  payload bytes written in the current frame.

Behaviour:
- Frame format, in byte order:
  - SYNC.
  - addr_lo, addr_hi: start address, little-endian; bits above ADDR_W ignored.
  - len_lo, len_hi: payload length, 16 bits.
  - len payload bytes.
  - One checksum byte: XOR of all payload bytes (0x00 when len=0).
- Accept rule: a byte is accepted when `in_valid && in_ready`.
- Reset values: state IDLE; `wr_valid`=0; `wr_addr`=0; `wr_data`=0; `cpu_hold`=1; `load_done`=0; `load_err`=0; `err_code`=0; `bytes_written`=0; `in_ready`=0 during reset.
- `in_ready`:
  - 1 in IDLE and HDR.
  - In DATA and CSUM: `!wr_valid || wr_ready`.
  - 0 in ERR.
- States:
  - IDLE: an accepted byte equal to SYNC goes to HDR; clears `err_code` and `bytes_written`; sets `cpu_hold`=1. Any other byte is dropped and the state stays IDLE.
  - HDR: accepts exactly 4 bytes (hdr_cnt 0..3).
    - On the 4th byte, if addr+len > DEPTH (computed 17 bits wide, no wrap), go to ERR with `err_code`=1.
    - Else if len=0, go to CSUM.
    - Else go to DATA with remaining=len and cur_addr=addr.
  - DATA: each accepted byte is registered to `wr_data`/`wr_addr`=cur_addr with `wr_valid`=1 the next cycle (latency 1).
    - `wr_valid` holds with stable addr/data until `wr_ready`.
    - Accept plus retire in the same cycle is allowed, giving back-to-back writes.
    - Per accepted byte: csum ^= byte; cur_addr++; remaining--; `bytes_written`++ on retire.
    - Accepting the last byte goes to CSUM.
  - CSUM: accepting the checksum byte (only once the last write has retired or retires this cycle, by the `in_ready` rule):
    - Match: `load_done` pulse next cycle, `cpu_hold`=0, return to IDLE.
    - Mismatch: `load_err` pulse, `err_code`=2, `cpu_hold` stays 1, return to IDLE.
  - ERR: one cycle; `load_err` pulse; no writes issued; return to IDLE. Remaining bytes of the bad frame are consumed in IDLE as non-SYNC garbage; a payload byte equal to SYNC can start a spurious frame, which is accepted behaviour.
- Checksum failure does not undo writes already performed.
- SYNC arriving in HDR/DATA/CSUM is treated as data, never as a resync.
- Synchronous reset mid-frame:
  - Aborts the frame and drops any pending write (`wr_valid`=0 next cycle).
  - Returns to IDLE with `cpu_hold`=1.
- `wr_valid` must never drop without `wr_ready`; `wr_addr` never exceeds DEPTH-1.

Decomposition:
- Shared package y86_pkg:
  - `IMEM_DEPTH`, `IMEM_ADDR_W`, `LOADER_SYNC`.
  - `loader_state_t` enum {IDLE, HDR, DATA, CSUM, ERR}.
  - `loader_err_t` {ERR_NONE, ERR_RANGE, ERR_CSUM}.
- One natural sub-module: `y86_imem_wr_stage`, the single-entry write output register with valid/ready hold, used by DATA. The FSM, counters and checksum stay in the top.

Test Plan:
- Frame A5 00 00 03 00 30 F4 00, checksum C4, `wr_ready`=1 → writes (0,30),(1,F4),(2,00) on consecutive cycles; `load_done` 1 cycle; `cpu_hold` 1→0; `bytes_written`=3.
- Same frame, `wr_ready` low 3 cycles on the 2nd write → `wr_valid`/addr 1/data F4 held stable; `in_ready`=0 during the stall; no byte lost; `load_done` still asserted.
- Header addr=0x3FE, len=3 → `load_err`, `err_code`=1, no `wr_valid`, `cpu_hold`=1; following valid frame loads normally.
- Frame with len=2, payload 10 20, checksum 00 (correct is 30) → both bytes written; `load_err`, `err_code`=2, `cpu_hold`=1.
- Garbage 00 FF 12, then A5 at addr 0x3FF with len=1, payload 00, checksum 00 → garbage dropped; write at 0x3FF; `load_done`.
- Reset asserted mid-DATA with `wr_valid` high and `wr_ready`=0 → next cycle `wr_valid`=0, state IDLE, `cpu_hold`=1, `err_code`=0.
